// File: rtl/trap_pkg.sv
`default_nettype none
// trap_pkg: shared state encoding, cause indices and legal memory-access codes
// for the trap controller. Revision 1.0.
package trap_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FLUSH   = 3'd1,
    VECTOR  = 3'd2,
    HANDLER = 3'd3,
    RETURN  = 3'd4
  } trap_state_t;

  localparam logic [2:0] SRC_MEMREAD  = 3'd0;
  localparam logic [2:0] SRC_MEMWRITE = 3'd1;
  localparam logic [2:0] SRC_ALU      = 3'd2;
  localparam logic [2:0] SRC_BRANCH   = 3'd3;

  localparam logic [3:0] MEM_CODE_OFF  = 4'b0000;
  localparam logic [3:0] MEM_CODE_ONE  = 4'b0001;
  localparam logic [3:0] MEM_CODE_FULL = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/trap_detect.sv
`default_nettype none
// trap_detect: combinational priority fault detector for the EXE stage.
// Revision 1.0.
module trap_detect
  import trap_pkg::*;
#(
  parameter int              PC_W       = 15,
  parameter int              CODE_W     = 4,
  parameter int              ALU_MAX    = 8,
  parameter logic [PC_W-1:0] ADDR_LIMIT = 15'h2000
) (
  input  logic              exe_valid,
  input  logic [CODE_W-1:0] memread_exe,
  input  logic [CODE_W-1:0] memwrite_exe,
  input  logic [CODE_W-1:0] aluop_exe,
  input  logic [PC_W-1:0]   branch_address,
  output logic              fault,
  output logic [2:0]        src,
  output logic [PC_W-1:0]   info
);

  logic memread_bad;
  logic memwrite_bad;
  logic alu_bad;
  logic branch_bad;

  always_comb begin
    memread_bad  = !((memread_exe == CODE_W'(MEM_CODE_OFF)) ||
                     (memread_exe == CODE_W'(MEM_CODE_ONE)) ||
                     (memread_exe == CODE_W'(MEM_CODE_FULL)));
    memwrite_bad = !((memwrite_exe == CODE_W'(MEM_CODE_OFF)) ||
                     (memwrite_exe == CODE_W'(MEM_CODE_ONE)) ||
                     (memwrite_exe == CODE_W'(MEM_CODE_FULL)));
    alu_bad      = (aluop_exe > CODE_W'(ALU_MAX));
    branch_bad   = (branch_address > ADDR_LIMIT);
  end

  // Lowest source index wins; nothing is reported for a bubble.
  always_comb begin
    fault = 1'b0;
    src   = SRC_MEMREAD;
    info  = '0;
    if (exe_valid) begin
      if (memread_bad) begin
        fault = 1'b1;
        src   = SRC_MEMREAD;
        info  = PC_W'(memread_exe);
      end else if (memwrite_bad) begin
        fault = 1'b1;
        src   = SRC_MEMWRITE;
        info  = PC_W'(memwrite_exe);
      end else if (alu_bad) begin
        fault = 1'b1;
        src   = SRC_ALU;
        info  = PC_W'(aluop_exe);
      end else if (branch_bad) begin
        fault = 1'b1;
        src   = SRC_BRANCH;
        info  = branch_address;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/trap_controller.sv
`default_nettype none
// trap_controller: takes EXE-stage traps, flushes the pipe, vectors to the
// handler and returns to SEPC on sret. Revision 1.0.
module trap_controller
  import trap_pkg::*;
#(
  parameter int              PC_W         = 15,
  parameter int              CAUSE_W      = 64,
  parameter int              CODE_W       = 4,
  parameter int              ALU_MAX      = 8,
  parameter logic [PC_W-1:0] ADDR_LIMIT   = 15'h2000,
  parameter logic [PC_W-1:0] TRAP_VECTOR  = 15'h1F00,
  parameter int              FLUSH_CYCLES = 2,
  parameter int              COUNT_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               exe_valid,
  input  logic [PC_W-1:0]    pc,
  input  logic [CODE_W-1:0]  memread_exe,
  input  logic [CODE_W-1:0]  memwrite_exe,
  input  logic [CODE_W-1:0]  aluop_exe,
  input  logic [PC_W-1:0]    branch_address,
  input  logic               sret,
  output logic               exception,
  output logic               flush,
  output logic               redirect_valid,
  output logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    sepc,
  output logic [CAUSE_W-1:0] scause,
  output logic               busy,
  output logic               double_fault,
  output logic [COUNT_W-1:0] trap_count
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_CYCLES - 1);

  trap_state_t          state;
  trap_state_t          state_next;
  logic [CNT_W-1:0]     flush_cnt;
  logic [CNT_W-1:0]     flush_cnt_next;
  logic                 take_trap;
  logic                 fault;
  logic [2:0]           src;
  logic [PC_W-1:0]      info;
  logic [CAUSE_W-1:0]   scause_next;

  trap_detect #(
    .PC_W       (PC_W),
    .CODE_W     (CODE_W),
    .ALU_MAX    (ALU_MAX),
    .ADDR_LIMIT (ADDR_LIMIT)
  ) u_detect (
    .exe_valid      (exe_valid),
    .memread_exe    (memread_exe),
    .memwrite_exe   (memwrite_exe),
    .aluop_exe      (aluop_exe),
    .branch_address (branch_address),
    .fault          (fault),
    .src            (src),
    .info           (info)
  );

  always_comb begin
    scause_next                    = '0;
    scause_next[CAUSE_W-1 -: 3]    = src;
    scause_next[PC_W-1:0]          = info;
  end

  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    take_trap      = 1'b0;
    case (state)
      IDLE: begin
        if (fault) begin
          take_trap  = 1'b1;
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        // Faults here belong to squashed instructions and are dropped.
        if (flush_cnt == CNT_LAST) begin
          flush_cnt_next = '0;
          state_next     = VECTOR;
        end else begin
          flush_cnt_next = flush_cnt + 1'b1;
        end
      end
      VECTOR:  state_next = HANDLER;
      HANDLER: if (sret) state_next = RETURN;
      RETURN:  state_next = IDLE;
      default: begin
        state_next     = IDLE;
        flush_cnt_next = '0;
      end
    endcase
  end

  always_comb begin
    flush          = (state == FLUSH);
    busy           = (state != IDLE);
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (state == VECTOR) begin
      redirect_valid = 1'b1;
      redirect_pc    = TRAP_VECTOR;
    end else if (state == RETURN) begin
      redirect_valid = 1'b1;
      redirect_pc    = sepc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      flush_cnt    <= '0;
      exception    <= 1'b0;
      sepc         <= '0;
      scause       <= '0;
      double_fault <= 1'b0;
      trap_count   <= '0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
      exception <= take_trap;
      if (take_trap) begin
        sepc   <= pc;
        scause <= scause_next;
        if (trap_count != '1) trap_count <= trap_count + 1'b1;
      end
      // A nested fault only flags; the saved trap state stays intact.
      if ((state == HANDLER) && fault) double_fault <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trap_controller.sv
`default_nettype none
// tb_trap_controller: directed self-checking bench for trap_controller.
// Revision 1.0.
module tb_trap_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        exe_valid;
  logic [14:0] pc;
  logic [3:0]  memread_exe;
  logic [3:0]  memwrite_exe;
  logic [3:0]  aluop_exe;
  logic [14:0] branch_address;
  logic        sret;
  logic        exception;
  logic        flush;
  logic        redirect_valid;
  logic [14:0] redirect_pc;
  logic [14:0] sepc;
  logic [63:0] scause;
  logic        busy;
  logic        double_fault;
  logic [7:0]  trap_count;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  trap_controller dut (
    .clk            (clk),
    .reset          (reset),
    .exe_valid      (exe_valid),
    .pc             (pc),
    .memread_exe    (memread_exe),
    .memwrite_exe   (memwrite_exe),
    .aluop_exe      (aluop_exe),
    .branch_address (branch_address),
    .sret           (sret),
    .exception      (exception),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .sepc           (sepc),
    .scause         (scause),
    .busy           (busy),
    .double_fault   (double_fault),
    .trap_count     (trap_count)
  );

  // {exception, flush, redirect_valid, busy}
  logic [3:0] status;
  assign status = {exception, flush, redirect_valid, busy};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    exe_valid      = 1'b0;
    pc             = '0;
    memread_exe    = '0;
    memwrite_exe   = '0;
    aluop_exe      = '0;
    branch_address = '0;
    sret           = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Full trap round trip driven through a memread fault; no checks.
  task automatic run_trap(input logic [14:0] p);
    exe_valid = 1'b1; pc = p; memread_exe = 4'b0010;
    tick();
    clear_inputs();
    tick(); tick(); tick();
    sret = 1'b1;
    tick();
    sret = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    vectors++;
    if ({status, redirect_pc, sepc, scause, double_fault, trap_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: status=%b rpc=%h sepc=%h scause=%h df=%b cnt=%0d, want all 0",
               status, redirect_pc, sepc, scause, double_fault, trap_count);
    end
    reset = 1'b0;
    tick();
    vectors++;
    if (status !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_release: status=%b want 0000", status);
    end
  endtask

  task automatic test_memread();
    do_reset();
    exe_valid = 1'b1; pc = 15'h0040; memread_exe = 4'b0010;
    tick();
    // Fault presented during flush must be ignored.
    exe_valid = 1'b1; pc = 15'h0099; memwrite_exe = 4'b0011; memread_exe = '0;
    vectors++;
    if (status !== 4'b1101 || sepc !== 15'h0040 || scause !== 64'h0000_0000_0000_0002) begin
      miscompares++;
      $display("FAIL memread_t1: status=%b sepc=%h scause=%h want 1101/0040/0000000000000002",
               status, sepc, scause);
    end
    tick();
    clear_inputs();
    vectors++;
    if (status !== 4'b0101 || redirect_pc !== 15'h0) begin
      miscompares++;
      $display("FAIL memread_t2: status=%b rpc=%h want 0101/0000", status, redirect_pc);
    end
    tick();
    vectors++;
    if (status !== 4'b0011 || redirect_pc !== 15'h1F00 || sepc !== 15'h0040 || trap_count !== 8'd1) begin
      miscompares++;
      $display("FAIL memread_vector: status=%b rpc=%h sepc=%h cnt=%0d want 0011/1f00/0040/1",
               status, redirect_pc, sepc, trap_count);
    end
    tick();
    vectors++;
    if (status !== 4'b0001 || redirect_pc !== 15'h0) begin
      miscompares++;
      $display("FAIL handler_idle: status=%b rpc=%h want 0001/0000", status, redirect_pc);
    end
    sret = 1'b1;
    tick();
    sret = 1'b0;
    vectors++;
    if (status !== 4'b0011 || redirect_pc !== 15'h0040) begin
      miscompares++;
      $display("FAIL sret_return: status=%b rpc=%h want 0011/0040", status, redirect_pc);
    end
    tick();
    vectors++;
    if (status !== 4'b0000 || redirect_pc !== 15'h0) begin
      miscompares++;
      $display("FAIL sret_idle: status=%b rpc=%h want 0000/0000", status, redirect_pc);
    end
    // sret outside HANDLER does nothing.
    sret = 1'b1;
    tick();
    sret = 1'b0;
    vectors++;
    if (status !== 4'b0000 || double_fault !== 1'b0) begin
      miscompares++;
      $display("FAIL sret_in_idle: status=%b df=%b want 0000/0", status, double_fault);
    end
  endtask

  task automatic test_priority();
    do_reset();
    exe_valid = 1'b1; pc = 15'h0123; memwrite_exe = 4'b0011; aluop_exe = 4'b1001;
    tick();
    clear_inputs();
    vectors++;
    if (exception !== 1'b1 || scause !== 64'h2000_0000_0000_0003 || trap_count !== 8'd1) begin
      miscompares++;
      $display("FAIL priority: exc=%b scause=%h cnt=%0d want 1/2000000000000003/1",
               exception, scause, trap_count);
    end
  endtask

  task automatic test_legal_boundary();
    do_reset();
    exe_valid = 1'b1; pc = 15'h0010;
    memread_exe = 4'b1111; memwrite_exe = 4'b0001; aluop_exe = 4'd8; branch_address = 15'h2000;
    tick();
    clear_inputs();
    vectors++;
    if (status !== 4'b0000 || trap_count !== 8'd0) begin
      miscompares++;
      $display("FAIL legal_boundary: status=%b cnt=%0d want 0000/0", status, trap_count);
    end
  endtask

  task automatic test_branch();
    do_reset();
    exe_valid = 1'b0; pc = 15'h0300; branch_address = 15'h2001;
    tick();
    vectors++;
    if (status !== 4'b0000) begin
      miscompares++;
      $display("FAIL branch_invalid: status=%b want 0000", status);
    end
    exe_valid = 1'b1;
    tick();
    clear_inputs();
    vectors++;
    if (exception !== 1'b1 || scause !== 64'h6000_0000_0000_2001 || sepc !== 15'h0300) begin
      miscompares++;
      $display("FAIL branch_valid: exc=%b scause=%h sepc=%h want 1/6000000000002001/0300",
               exception, scause, sepc);
    end
  endtask

  task automatic test_double_fault();
    do_reset();
    exe_valid = 1'b1; pc = 15'h0100; aluop_exe = 4'b1001;
    tick();
    clear_inputs();
    tick(); tick(); tick();
    exe_valid = 1'b1; pc = 15'h0123; aluop_exe = 4'b1111; sret = 1'b1;
    tick();
    clear_inputs();
    vectors++;
    if (status !== 4'b0011 || redirect_pc !== 15'h0100 || double_fault !== 1'b1 ||
        sepc !== 15'h0100 || scause !== 64'h4000_0000_0000_0009 || trap_count !== 8'd1) begin
      miscompares++;
      $display("FAIL double_fault: status=%b rpc=%h df=%b sepc=%h scause=%h cnt=%0d want 0011/0100/1/0100/4000000000000009/1",
               status, redirect_pc, double_fault, sepc, scause, trap_count);
    end
    tick();
    // Back-to-back: new fault in the first IDLE cycle after RETURN.
    exe_valid = 1'b1; pc = 15'h0200; memwrite_exe = 4'b0010;
    tick();
    clear_inputs();
    vectors++;
    if (exception !== 1'b1 || sepc !== 15'h0200 || scause !== 64'h2000_0000_0000_0002 ||
        trap_count !== 8'd2 || double_fault !== 1'b1) begin
      miscompares++;
      $display("FAIL back_to_back: exc=%b sepc=%h scause=%h cnt=%0d df=%b want 1/0200/2000000000000002/2/1",
               exception, sepc, scause, trap_count, double_fault);
    end
  endtask

  // Entered while the previous test leaves the DUT in FLUSH.
  task automatic test_reset_mid_flush();
    vectors++;
    if (flush !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_flush: flush=%b want 1", flush);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if ({status, redirect_pc, sepc, scause, double_fault, trap_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_flush: status=%b rpc=%h sepc=%h scause=%h df=%b cnt=%0d want all 0",
               status, redirect_pc, sepc, scause, double_fault, trap_count);
    end
    tick();
    vectors++;
    if (status !== 4'b0000) begin
      miscompares++;
      $display("FAIL post_reset_idle: status=%b want 0000", status);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 255; i++) run_trap(15'(i));
    vectors++;
    if (trap_count !== 8'd255) begin
      miscompares++;
      $display("FAIL count_255: cnt=%0d want 255", trap_count);
    end
    for (int i = 255; i < 300; i++) run_trap(15'(i));
    vectors++;
    if (trap_count !== 8'd255 || sepc !== 15'd299 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL count_saturate: cnt=%0d sepc=%0d busy=%b want 255/299/0",
               trap_count, sepc, busy);
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_memread();
    test_priority();
    test_legal_boundary();
    test_branch();
    test_double_fault();
    test_reset_mid_flush();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
